branch_resolve_unit: RTL and testbench

//   Pipelined successor of the single-cycle branch AND gate. Resolves all RV32I conditional branches and JAL/JALR in EX

---
 rtl/branch_resolve_unit_pkg.sv | 37 +++
 rtl/branch_resolve_unit_if.sv | 47 ++++
 rtl/branch_resolve_unit_sat_counter2.sv | 26 ++
 rtl/branch_resolve_unit.sv | 80 ++++++++
 tb/tb_branch_resolve_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolver: funct3 encodings,
// 2-bit predictor counter states and the branch condition evaluator.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr2_e;

    // Flags come from rs1-rs2; carry=1 means no borrow (rs1 >= rs2 unsigned).
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic zero, input logic neg,
                                         input logic ovf,  input logic carry);
        logic c;
        c = 1'b0;
        case (funct3)
            F3_BEQ:  c = zero;
            F3_BNE:  c = ~zero;
            F3_BLT:  c = neg ^ ovf;
            F3_BGE:  c = ~(neg ^ ovf);
            F3_BLTU: c = ~carry;
            F3_BGEU: c = carry;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-side bundle of the branch resolver. The pipeline is the master,
// the resolver the slave.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;

    logic             ex_valid;
    logic             ex_branch;
    logic             ex_jump;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic             ex_zero;
    logic             ex_neg;
    logic             ex_ovf;
    logic             ex_carry;

    logic             take_branch;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             illegal_branch;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_pc,
        output ex_valid, ex_branch, ex_jump, ex_funct3, ex_pc, ex_target, ex_pred_taken,
        output ex_zero, ex_neg, ex_ovf, ex_carry,
        input  if_pred_taken, take_branch, mispredict, redirect_pc,
        input  flush_if_id, flush_id_ex, illegal_branch, branch_count, mispred_count
    );

    modport slave (
        input  if_pc,
        input  ex_valid, ex_branch, ex_jump, ex_funct3, ex_pc, ex_target, ex_pred_taken,
        input  ex_zero, ex_neg, ex_ovf, ex_carry,
        output if_pred_taken, take_branch, mispredict, redirect_pc,
        output flush_if_id, flush_id_ex, illegal_branch, branch_count, mispred_count
    );

endinterface

// File: rtl/branch_resolve_unit_sat_counter2.sv
// One BHT entry: 2-bit saturating up/down counter with a reset-time initial value.
module sat_counter2
    import branch_resolve_unit_pkg::*;
#(
    parameter logic [1:0] INIT = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output logic [1:0] ctr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= INIT;
        end else if (en) begin
            if (up && ctr != ST) begin
                ctr <= ctr + 2'd1;
            end else if (!up && ctr != SNT) begin
                ctr <= ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver with misprediction redirect, a direct-mapped
// 2-bit BHT feeding fetch, and saturating branch/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_resolve_unit_if.slave bru
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond;
    logic             illegal;
    logic             take;
    logic             resolve;
    logic             mispred;
    logic             bht_upd;
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] mispred_count_q;

    // PC bits [1:0] are dropped; PCs sharing an index alias by design.
    assign if_idx = bru.if_pc[IDX_W+1:2];
    assign ex_idx = bru.ex_pc[IDX_W+1:2];

    // Fetch sees the registered counter, so a same-cycle update is not bypassed.
    assign bru.if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        cond    = branch_cond(bru.ex_funct3, bru.ex_zero, bru.ex_neg, bru.ex_ovf, bru.ex_carry);
        illegal = bru.ex_valid & bru.ex_branch & (bru.ex_funct3[2:1] == 2'b01);
        resolve = bru.ex_valid & (bru.ex_branch | bru.ex_jump);
        take    = bru.ex_valid & (bru.ex_jump | (bru.ex_branch & cond));
        mispred = resolve & (take != bru.ex_pred_taken);
        bht_upd = bru.ex_valid & bru.ex_branch & ~bru.ex_jump & ~illegal;
    end

    assign bru.take_branch    = take;
    assign bru.mispredict     = mispred;
    assign bru.flush_if_id    = mispred;
    assign bru.flush_id_ex    = mispred;
    assign bru.illegal_branch = illegal;
    assign bru.redirect_pc    = take ? bru.ex_target : (bru.ex_pc + XLEN'(4));

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter2 #(.INIT(CTR_INIT)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bht_upd && (ex_idx == IDX_W'(i))),
            .up    (take),
            .ctr   (bht_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (resolve && !(&branch_count_q)) begin
                branch_count_q <= branch_count_q + CNT_W'(1);
            end
            if (mispred && !(&mispred_count_q)) begin
                mispred_count_q <= mispred_count_q + CNT_W'(1);
            end
        end
    end

    assign bru.branch_count  = branch_count_q;
    assign bru.mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected EX results are queued at
// drive time and compared when the combinational outputs settle.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bru ();

    branch_resolve_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (16),
        .CTR_INIT    (2'b01),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bru   (bru)
    );

    typedef struct {
        logic        take;
        logic        mis;
        logic        ill;
        logic        pred;
        logic [31:0] redir;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  m_bht [16];
    logic [15:0] m_bcnt;
    logic [15:0] m_mcnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] f3, input logic z, input logic n,
                                      input logic v, input logic c);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic issue(input logic v, input logic b, input logic j, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pr,
                         input logic [3:0] fl);
        exp_t e;
        exp_t got;
        logic ill;
        logic [3:0] idx;
        idx = pc[5:2];
        bru.if_pc         = pc;
        bru.ex_valid      = v;
        bru.ex_branch     = b;
        bru.ex_jump       = j;
        bru.ex_funct3     = f3;
        bru.ex_pc         = pc;
        bru.ex_target     = tgt;
        bru.ex_pred_taken = pr;
        {bru.ex_zero, bru.ex_neg, bru.ex_ovf, bru.ex_carry} = fl;
        ill     = v && b && (f3 == 3'b010 || f3 == 3'b011);
        e.ill   = ill;
        e.take  = v && (j || (b && ref_cond(f3, fl[3], fl[2], fl[1], fl[0])));
        e.mis   = v && (b || j) && (e.take != pr);
        e.redir = e.take ? tgt : pc + 32'd4;
        e.pred  = m_bht[idx][1];
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        check_val("take_branch", {31'd0, bru.take_branch}, {31'd0, got.take});
        check_val("mispredict", {31'd0, bru.mispredict}, {31'd0, got.mis});
        check_val("flush_if_id", {31'd0, bru.flush_if_id}, {31'd0, got.mis});
        check_val("flush_id_ex", {31'd0, bru.flush_id_ex}, {31'd0, got.mis});
        check_val("illegal_branch", {31'd0, bru.illegal_branch}, {31'd0, got.ill});
        check_val("redirect_pc", bru.redirect_pc, got.redir);
        check_val("if_pred_taken", {31'd0, bru.if_pred_taken}, {31'd0, got.pred});
        @(posedge clk);
        if (v && b && !j && !ill) begin
            if (e.take && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
            else if (!e.take && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
        end
        if (v && (b || j) && m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
        if (e.mis && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
        #1;
        check_val("branch_count", {16'd0, bru.branch_count}, {16'd0, m_bcnt});
        check_val("mispred_count", {16'd0, bru.mispred_count}, {16'd0, m_mcnt});
    endtask

    task automatic probe_pred(input string tag, input logic [31:0] pc, input logic exp);
        bru.if_pc = pc;
        #1;
        check_val(tag, {31'd0, bru.if_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        bru.if_pc = '0; bru.ex_valid = 0; bru.ex_branch = 0; bru.ex_jump = 0;
        bru.ex_funct3 = '0; bru.ex_pc = '0; bru.ex_target = '0; bru.ex_pred_taken = 0;
        bru.ex_zero = 0; bru.ex_neg = 0; bru.ex_ovf = 0; bru.ex_carry = 0;
        model_reset();
        #12;
        check_val("rst_branch_count", {16'd0, bru.branch_count}, 32'd0);
        check_val("rst_mispred_count", {16'd0, bru.mispred_count}, 32'd0);
        check_val("rst_pred", {31'd0, bru.if_pred_taken}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BEQ taken against a not-taken guess, then the entry reads weakly taken.
        issue(1, 1, 0, 3'b000, 32'h40, 32'h100, 0, 4'b1000);
        probe_pred("t1_pred_after", 32'h40, 1'b1);

        // Fixed corner cases of the condition table.
        issue(1, 1, 0, 3'b100, 32'h200, 32'h300, 1, 4'b0110); // BLT n=1 v=1: not taken
        issue(1, 1, 0, 3'b110, 32'h204, 32'h310, 0, 4'b0000); // BLTU carry=0: taken

        // Counter walk on one entry.
        for (int i = 0; i < 4; i++) issue(1, 1, 0, 3'b001, 32'h84, 32'h500, 0, 4'b0000);
        probe_pred("t3_sat_taken", 32'h84, 1'b1);
        for (int i = 0; i < 2; i++) issue(1, 1, 0, 3'b001, 32'h84, 32'h500, 1, 4'b1000);
        probe_pred("t3_back_weak_nt", 32'h84, 1'b0);

        // Illegal encodings and jumps leave the BHT alone.
        issue(1, 1, 0, 3'b010, 32'h88, 32'h600, 1, 4'b1111);
        issue(1, 1, 0, 3'b011, 32'h88, 32'h600, 0, 4'b0000);
        issue(1, 0, 1, 3'b000, 32'h8C, 32'h700, 0, 4'b0000);
        issue(1, 1, 1, 3'b001, 32'h8C, 32'h700, 1, 4'b1000);
        probe_pred("t4_jal_no_bht", 32'h8C, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 16; fl++) begin
                issue(1, 1, 0, 3'(f), 32'h1000 + ($urandom_range(0, 63) << 2),
                      32'h2000 + ($urandom_range(0, 255) << 2), 1'($urandom_range(0, 1)), 4'(fl));
            end
        end
        issue(0, 1, 0, 3'b000, 32'h90, 32'h900, 0, 4'b1000);
        issue(0, 0, 1, 3'b000, 32'h90, 32'h900, 1, 4'b0000);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_branch_count", {16'd0, bru.branch_count}, 32'd0);
        check_val("midrst_mispred_count", {16'd0, bru.mispred_count}, 32'd0);
        for (int i = 0; i < 16; i++) probe_pred("midrst_bht", 32'(i << 2), 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 1, 0, 3'b111, 32'h40, 32'h140, 0, 4'b0001);
        probe_pred("post_rst_init_01", 32'h40, 1'b1);

        // Drive branch_count up to 0xFFFE, then past saturation.
        while (m_bcnt != 16'hFFFE) issue(1, 0, 1, 3'b000, 32'h10, 32'h20, 1, 4'b0000);
        check_val("cnt_at_fffe", {16'd0, bru.branch_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) issue(1, 1, 0, 3'b000, 32'h14, 32'h24, 0, 4'b0000);
        check_val("cnt_sat", {16'd0, bru.branch_count}, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) issue(0, 1, 0, 3'b000, 32'h14, 32'h24, 0, 4'b1000);
        check_val("cnt_hold", {16'd0, bru.branch_count}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
